// File: rtl/surf_splice_pkg.sv
// Shared types and helpers for the multi-SURF DOUT splice.
// The optional per-channel header byte is enabled by defining SURF_SPLICE_HDR_EN.
package surf_splice_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } splice_state_e;

  // Counter/pointer widths for the default configuration.
  localparam int unsigned FrameCntW = $clog2(64);
  localparam int unsigned FifoPtrW  = $clog2(256);
  localparam int unsigned ChanW     = $clog2(7);

  // Width helper that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic masked, input logic [3:0] ch);
    return {masked, 3'b000, ch};
  endfunction

endpackage

// File: rtl/surf_splice_fifo.sv
// First-word-fall-through FIFO; o_rd_data shows the head whenever o_empty is low.
// A write on a full FIFO succeeds when a read happens in the same cycle.
module surf_splice_fifo
  import surf_splice_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_rd   = i_rd_en && !o_empty;
  assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/surf_dout_splice_multi.sv
// Merges NCHAN SURF DOUT byte streams into one framed AXI4-Stream event per trigger.
// Define SURF_SPLICE_HDR_EN to prefix each channel's bytes with a header byte.
module surf_dout_splice_multi
  import surf_splice_pkg::*;
#(
  parameter int unsigned NCHAN      = 7,
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned TRIG_DEPTH = 16,
  parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               trig_i,
  input  logic [NCHAN-1:0]   mask_i,
  input  logic               mask_ce_i,
  input  logic [NCHAN*8-1:0] s_dout_tdata,
  input  logic [NCHAN-1:0]   s_dout_tvalid,
  output logic [7:0]         m_dout_tdata,
  output logic               m_dout_tvalid,
  input  logic               m_dout_tready,
  output logic               m_dout_tlast,
  output logic               busy_o,
  output logic [NCHAN-1:0]   overflow_o,
  output logic               trig_overflow_o
);

  localparam int unsigned     ChW     = cnt_w(NCHAN);
  localparam int unsigned     CntW    = cnt_w(FRAME_LEN);
  localparam logic [ChW-1:0]  LastCh  = ChW'(NCHAN - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);
`ifdef SURF_SPLICE_HDR_EN
  localparam splice_state_e   ChStart = StHdr;
`else
  localparam splice_state_e   ChStart = StData;
`endif

  splice_state_e    r_state;
  splice_state_e    w_state_nxt;
  logic [NCHAN-1:0] r_live_mask;
  logic [NCHAN-1:0] r_snap;
  logic [NCHAN-1:0] r_trig_mask;
  logic             r_trig;
  logic [ChW-1:0]   r_ch;
  logic [CntW-1:0]  r_cnt;
  logic [NCHAN-1:0] r_ovf;
  logic             r_trig_ovf;

  logic [NCHAN-1:0] w_wr;
  logic [NCHAN-1:0] w_pop;
  logic [NCHAN-1:0] w_full;
  logic [NCHAN-1:0] w_empty;
  logic [7:0]       w_head [NCHAN];
  logic [NCHAN-1:0] w_q_mask;
  logic             w_q_full;
  logic             w_q_empty;
  logic             w_q_pop;
  logic             w_beat;
  logic             w_data_pop;
  logic             w_cur_masked;
  logic             w_cur_empty;
  logic [7:0]       w_cur_head;
  logic             w_ch_end;

  assign w_wr         = s_dout_tvalid & ~r_live_mask;
  assign w_cur_masked = r_snap[r_ch];
  assign w_cur_empty  = w_empty[r_ch];
  assign w_cur_head   = w_head[r_ch];
  assign w_beat       = m_dout_tvalid && m_dout_tready;
  assign w_data_pop   = (r_state == StData) && w_beat && !w_cur_masked;
  assign w_ch_end     = (r_state == StData) && w_beat && (r_cnt == LastCnt);
  assign w_q_pop      = (r_state == StDone);

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign w_pop[c] = w_data_pop && (r_ch == ChW'(c));

    surf_splice_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk     (aclk),
      .i_rst_n   (aresetn),
      .i_wr_en   (w_wr[c]),
      .i_wr_data (s_dout_tdata[8*c +: 8]),
      .i_rd_en   (w_pop[c]),
      .o_rd_data (w_head[c]),
      .o_full    (w_full[c]),
      .o_empty   (w_empty[c])
    );
  end

  // Trigger and its pre-update mask are registered once before entering the queue.
  surf_splice_fifo #(
    .WIDTH (NCHAN),
    .DEPTH (TRIG_DEPTH)
  ) u_trig_q (
    .i_clk     (aclk),
    .i_rst_n   (aresetn),
    .i_wr_en   (r_trig),
    .i_wr_data (r_trig_mask),
    .i_rd_en   (w_q_pop),
    .o_rd_data (w_q_mask),
    .o_full    (w_q_full),
    .o_empty   (w_q_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_live_mask <= '1;
      r_trig      <= 1'b0;
      r_trig_mask <= '0;
      r_ovf       <= '0;
      r_trig_ovf  <= 1'b0;
    end else begin
      if (mask_ce_i) r_live_mask <= mask_i;
      r_trig      <= trig_i;
      r_trig_mask <= r_live_mask;
      r_ovf       <= r_ovf | (w_wr & w_full & ~w_pop);
      if (r_trig && w_q_full && !w_q_pop) r_trig_ovf <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_snap <= '0;
      r_ch   <= '0;
      r_cnt  <= '0;
    end else if (r_state == StIdle && !w_q_empty) begin
      r_snap <= w_q_mask;
      r_ch   <= '0;
      r_cnt  <= '0;
    end else if (r_state == StData && w_beat) begin
      if (r_cnt == LastCnt) begin
        r_cnt <= '0;
        if (r_ch != LastCh) r_ch <= r_ch + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (!w_q_empty) w_state_nxt = ChStart;
      StHdr:   if (m_dout_tready) w_state_nxt = StData;
      StData:  if (w_ch_end) w_state_nxt = (r_ch == LastCh) ? StDone : ChStart;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    m_dout_tvalid = 1'b0;
    m_dout_tdata  = '0;
    m_dout_tlast  = 1'b0;
    unique case (r_state)
      StHdr: begin
        m_dout_tvalid = 1'b1;
        m_dout_tdata  = hdr_byte(w_cur_masked, 4'(r_ch));
      end
      StData: begin
        m_dout_tvalid = w_cur_masked || !w_cur_empty;
        m_dout_tdata  = w_cur_masked ? FILL_BYTE : w_cur_head;
        m_dout_tlast  = (r_cnt == LastCnt) && (r_ch == LastCh);
      end
      default: ;
    endcase
  end

  assign busy_o          = (r_state != StIdle) || !w_q_empty;
  assign overflow_o      = r_ovf;
  assign trig_overflow_o = r_trig_ovf;

endmodule
